// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding access with byte-lane alignment,
// sign/zero extension, misalignment checks and a grant/response timeout.
module mem_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic        load_q, load_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] ea;
    logic        legal_f3;
    logic        misalign;
    logic        timeout;
    logic [31:0] ld_sh;
    logic [31:0] ld_val;
    logic [31:0] st_data;
    logic [3:0]  st_strb;

    assign ea      = base + imm;
    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        legal_f3 = 1'b0;
        if (is_load) begin
            legal_f3 = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else begin
            legal_f3 = funct3 inside {3'b000, 3'b001, 3'b010};
        end
        misalign = ((funct3[1:0] == 2'b01) && ea[0]) ||
                   ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    end

    // Little-endian: the addressed byte is moved down to lane 0 first.
    always_comb begin
        ld_sh  = mem_rdata >> {addr_q[1:0], 3'b000};
        ld_val = ld_sh;
        case (f3_q)
            3'b000:  ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b100:  ld_val = {24'd0, ld_sh[7:0]};
            3'b101:  ld_val = {16'd0, ld_sh[15:0]};
            default: ld_val = ld_sh;
        endcase
    end

    always_comb begin
        st_data = wdata_q;
        st_strb = 4'b1111;
        case (f3_q[1:0])
            2'b00: begin
                st_data = {4{wdata_q[7:0]}};
                st_strb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                st_data = {2{wdata_q[15:0]}};
                st_strb = 4'b0011 << addr_q[1:0];
            end
            default: begin
                st_data = wdata_q;
                st_strb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        load_d  = load_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_valid && (is_load ^ is_store)) begin
                    addr_d  = ea;
                    f3_d    = funct3;
                    load_d  = is_load;
                    wdata_d = wdata;
                    cnt_d   = 8'd0;
                    if (legal_f3 && !misalign) begin
                        err_d   = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_REQ: begin
                // A grant arriving on the last counted cycle still wins.
                if (mem_gnt) begin
                    cnt_d   = 8'd0;
                    state_d = load_q ? S_WAIT : S_RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = ld_val;
                    state_d = S_RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            f3_q    <= 3'd0;
            load_q  <= 1'b0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            load_q  <= load_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lsu_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_RESP);
    assign err       = (state_q == S_RESP) && err_q;
    assign rdata     = rdata_q;
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = (state_q == S_REQ) && !load_q;
    assign mem_wstrb = ((state_q == S_REQ) && !load_q) ? st_strb : 4'b0000;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = st_data;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: transaction-level model driving per-cycle expectations,
// plus literal checks of the key addresses, strobes, data and latencies.
module tb_mem_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, lsu_ready;
    logic        is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] base, imm, wdata;
    logic        done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    mem_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3),
        .base(base), .imm(imm), .wdata(wdata),
        .done(done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit          chk_en = 0;
    bit          exp_ready, exp_done, exp_err, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] model_rdata;

    int          obs_lat, obs_req;
    logic        obs_err;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic [3:0]  obs_wstrb;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ready", 32'(lsu_ready), 32'(exp_ready));
            cmp("done", 32'(done), 32'(exp_done));
            if (exp_done) cmp("err", 32'(err), 32'(exp_err));
            cmp("mem_req", 32'(mem_req), 32'(exp_req));
            cmp("rdata", rdata, exp_rdata);
            if (exp_req) begin
                cmp("mem_addr", mem_addr, exp_addr);
                cmp("mem_we", 32'(mem_we), 32'(exp_we));
                if (exp_we) begin
                    cmp("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                    cmp("mem_wdata", mem_wdata, exp_wdata);
                end
            end else begin
                cmp("we_idle", 32'(mem_we), 32'd0);
                cmp("wstrb_idle", 32'(mem_wstrb), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] m_strb(input logic [2:0] f3,
                                          input logic [31:0] a);
        int n;
        logic [3:0] s;
        n = 1 << f3[1:0];
        s = 4'd0;
        for (int k = 0; k < 4; k++)
            if (k >= a % 4 && k < a % 4 + n) s[k] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                            input logic [31:0] d);
        logic [31:0] r;
        if (f3 == 3'd0)      r = (d & 32'hFF) * 32'h01010101;
        else if (f3 == 3'd1) r = (d & 32'hFFFF) * 32'h00010001;
        else                 r = d;
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] d);
        longint v;
        int nb;
        nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        v = (longint'(d) >> (8 * (a % 4))) % (longint'(1) << (8 * nb));
        if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic bit m_bad(input bit ld, input logic [2:0] f3,
                                 input logic [31:0] a);
        int sz;
        if (ld && !(f3 inside {0, 1, 2, 4, 5})) return 1;
        if (!ld && f3 > 2) return 1;
        sz = 1 << f3[1:0];
        return (a % sz) != 0;
    endfunction

    task automatic set_exp(input bit rdy, input bit dn, input bit er,
                           input bit rq);
        exp_ready = rdy;
        exp_done  = dn;
        exp_err   = er;
        exp_req   = rq;
        exp_rdata = model_rdata;
    endtask

    task automatic sample(input int c);
        if (done && obs_lat < 0) begin
            obs_lat   = c;
            obs_err   = err;
            obs_rdata = rdata;
        end
        if (mem_req) begin
            if (obs_req == 0) begin
                obs_addr  = mem_addr;
                obs_wstrb = mem_wstrb;
                obs_wdata = mem_wdata;
            end
            obs_req++;
        end
    endtask

    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] b, input logic [31:0] i,
                         input logic [31:0] wd, input int gd, input int rd,
                         input logic [31:0] md);
        logic [31:0] ea;
        bit ef, got;
        int c;
        ea = b + i;
        ef = m_bad(ld, f3, ea);
        obs_lat = -1;
        obs_req = 0;
        obs_err = 1'bx;
        c = 0;
        set_exp(1, 0, 0, 0);
        lsu_valid = 1; is_load = ld; is_store = st; funct3 = f3;
        base = b; imm = i; wdata = wd;
        sample(c);
        tick(); c++;
        lsu_valid = 0; is_load = 0; is_store = 0;
        base = $urandom; imm = $urandom; wdata = $urandom;
        if (!ef) begin
            got = 0;
            for (int k = 0; k < TO; k++) begin
                set_exp(0, 0, 0, 1);
                exp_we    = st;
                exp_addr  = ea & 32'hFFFFFFFC;
                exp_wstrb = m_strb(f3, ea);
                exp_wdata = m_wdata(f3, wd);
                mem_gnt = (k == gd);
                mem_rvalid = (k == gd);
                mem_rdata  = 32'hBAD0BAD0;
                sample(c);
                tick(); c++;
                mem_gnt = 0;
                mem_rvalid = 0;
                if (k == gd) begin
                    got = 1;
                    break;
                end
            end
            ef = !got;
            if (got && ld) begin
                got = 0;
                for (int k = 0; k < TO; k++) begin
                    set_exp(0, 0, 0, 0);
                    mem_rvalid = (k == rd);
                    mem_rdata  = (k == rd) ? md : ~md;
                    mem_gnt    = 1;
                    sample(c);
                    tick(); c++;
                    mem_rvalid = 0;
                    mem_gnt    = 0;
                    if (k == rd) begin
                        got = 1;
                        model_rdata = m_load(f3, ea, md);
                        break;
                    end
                end
                ef = !got;
            end
        end
        set_exp(0, 1, ef, 0);
        sample(c);
        tick(); c++;
        set_exp(1, 0, 0, 0);
        sample(c);
        tick();
    endtask

    initial begin
        rst = 1; lsu_valid = 0; is_load = 0; is_store = 0; funct3 = 0;
        base = 0; imm = 0; wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        model_rdata = 0;
        set_exp(1, 0, 0, 0);
        exp_we = 0; exp_addr = 0; exp_wstrb = 0; exp_wdata = 0;
        tick(); tick();
        cmp("rst_ready", 32'(lsu_ready), 32'd1);
        cmp("rst_done", 32'(done), 32'd0);
        cmp("rst_err", 32'(err), 32'd0);
        cmp("rst_req", 32'(mem_req), 32'd0);
        cmp("rst_we", 32'(mem_we), 32'd0);
        cmp("rst_wstrb", 32'(mem_wstrb), 32'd0);
        cmp("rst_rdata", rdata, 32'd0);
        rst = 0;
        chk_en = 1;
        tick();

        do_op(0, 1, 3'b010, 32'h10, 32'h4, 32'hDEADBEEF, 0, 0, 0);
        cmp("sw_addr", obs_addr, 32'h14);
        cmp("sw_strb", 32'(obs_wstrb), 32'hF);
        cmp("sw_wdata", obs_wdata, 32'hDEADBEEF);
        cmp("sw_lat", 32'(obs_lat), 32'd2);
        cmp("sw_err", 32'(obs_err), 32'd0);

        do_op(0, 1, 3'b000, 32'h20, 32'h3, 32'h000000A5, 0, 0, 0);
        cmp("sb_addr", obs_addr, 32'h20);
        cmp("sb_strb", 32'(obs_wstrb), 32'h8);
        cmp("sb_wdata", obs_wdata, 32'hA5A5A5A5);

        do_op(1, 0, 3'b000, 32'h20, 32'h2, 0, 0, 0, 32'h12F03456);
        cmp("lb_rdata", obs_rdata, 32'hFFFFFFF0);
        cmp("lb_lat", 32'(obs_lat), 32'd3);
        do_op(1, 0, 3'b100, 32'h20, 32'h2, 0, 0, 0, 32'h12F03456);
        cmp("lbu_rdata", obs_rdata, 32'h000000F0);
        do_op(1, 0, 3'b101, 32'h20, 32'h2, 0, 0, 0, 32'h12F03456);
        cmp("lhu_rdata", obs_rdata, 32'h000012F0);

        do_op(1, 0, 3'b010, 32'h40, 32'h1, 0, 0, 0, 32'h11111111);
        cmp("lw_mis_err", 32'(obs_err), 32'd1);
        cmp("lw_mis_lat", 32'(obs_lat), 32'd1);
        cmp("lw_mis_req", 32'(obs_req), 32'd0);

        do_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 99, 0, 32'h22222222);
        cmp("gto_req", 32'(obs_req), 32'd4);
        cmp("gto_err", 32'(obs_err), 32'd1);
        cmp("gto_rdata", obs_rdata, 32'h000012F0);

        do_op(0, 1, 3'b001, 32'h30, 32'h2, 32'h1234BEEF, 2, 0, 0);
        cmp("sh_strb", 32'(obs_wstrb), 32'hC);
        cmp("sh_wdata", obs_wdata, 32'hBEEFBEEF);

        do_op(1, 0, 3'b001, 32'h40, 32'h6, 0, 1, 2, 32'h80017F00);
        cmp("lh_rdata", obs_rdata, 32'hFFFF8001);

        do_op(1, 0, 3'b010, 32'h200, 32'h0, 0, 0, 99, 32'h33333333);
        cmp("rto_err", 32'(obs_err), 32'd1);
        cmp("rto_rdata", obs_rdata, 32'hFFFF8001);

        do_op(1, 0, 3'b011, 32'h0, 32'h0, 0, 0, 0, 0);
        cmp("ill_ld_err", 32'(obs_err), 32'd1);
        do_op(0, 1, 3'b100, 32'h0, 32'h0, 0, 0, 0, 0);
        cmp("ill_st_err", 32'(obs_err), 32'd1);
        do_op(0, 1, 3'b001, 32'h0, 32'h1, 32'h5555, 0, 0, 0);
        cmp("sh_mis_req", 32'(obs_req), 32'd0);

        do_op(0, 1, 3'b010, 32'h50, 32'h0, 32'h600DF00D, TO - 1, 0, 0);
        cmp("gnt_last_err", 32'(obs_err), 32'd0);
        cmp("gnt_last_req", 32'(obs_req), 32'(TO));

        do_op(0, 1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h01020304, 0, 0, 0);
        cmp("wrap_addr", obs_addr, 32'h4);

        set_exp(1, 0, 0, 0);
        lsu_valid = 1; is_load = 1; is_store = 1; funct3 = 3'b010;
        tick();
        lsu_valid = 0; is_load = 0; is_store = 0;
        cmp("both_ready", 32'(lsu_ready), 32'd1);
        set_exp(1, 0, 0, 0);
        lsu_valid = 1; funct3 = 3'b010;
        tick();
        lsu_valid = 0;
        cmp("none_ready", 32'(lsu_ready), 32'd1);

        set_exp(1, 0, 0, 0);
        lsu_valid = 1; is_load = 1; funct3 = 3'b010; base = 32'h80; imm = 0;
        tick();
        lsu_valid = 0; is_load = 0;
        set_exp(0, 0, 0, 1);
        exp_we = 0; exp_addr = 32'h80;
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        set_exp(0, 0, 0, 0);
        rst = 1;
        tick();
        rst = 0;
        model_rdata = 0;
        set_exp(1, 0, 0, 0);
        cmp("rstw_ready", 32'(lsu_ready), 32'd1);
        mem_rvalid = 1; mem_rdata = 32'h55555555;
        tick();
        mem_rvalid = 0;
        cmp("rstw_done", 32'(done), 32'd0);
        cmp("rstw_rdata", rdata, 32'd0);
        tick(); tick();
        chk_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter TIMEOUT, 255, cycles to wait for mem_gnt or mem_rvalid before aborting with error (1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 lsu_valid  input  1  core presents a load/store operation.
REQ-005 lsu_ready  output  1  unit idle, accepts operation this cycle.
REQ-006 is_load / is_store  input  1 each  operation kind; both high or both low with lsu_valid is ignored (no accept).
REQ-007 funct3  input  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; for stores 000 sb, 001 sh, 010 sw; other codes flag error.
REQ-008 base, imm  input  32 each  effective address = base + imm, modulo 2^32.
REQ-009 wdata  input  32  store data, right-aligned.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rdata  output  32  load result, zero/sign-extended; valid while done high.
REQ-012 err  output  1  qualified by done; misaligned, illegal funct3, or timeout.
REQ-013 mem_req, mem_we  output  1 each  memory request, write enable.
REQ-014 mem_addr  output  32  word address, bits[1:0] always 00.
REQ-015 mem_wdata, mem_wstrb  output  32, 4  lane-shifted store data, byte strobes.
REQ-016 mem_gnt  input  1  memory accepts request this cycle.
REQ-017 mem_rvalid, mem_rdata  input  1, 32  read data return.

Function
REQ-018 FSM states IDLE, REQ, WAIT, RESP; lsu_ready = (state==IDLE).
REQ-019 IDLE: on lsu_valid with exactly one of is_load/is_store, latch address, funct3, kind, wdata; legal -> REQ, else -> RESP with err=1, no mem_req ever issued.
REQ-020 Misaligned: lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]!=00.
REQ-021 REQ: mem_req=1, held with stable addr/we/wdata/wstrb until mem_gnt; store+gnt -> RESP; load+gnt -> WAIT.
REQ-022 WAIT: on mem_rvalid capture lane-selected data, -> RESP; mem_rvalid outside WAIT ignored.
REQ-023 RESP: done=1 for exactly one cycle, then IDLE; earliest new accept is the cycle after done.
REQ-024 Byte order little-endian: byte at addr[1:0]=k occupies lane k (bits 8k+7:8k).
REQ-025 Stores: sb wstrb = 0001<<addr[1:0], wdata byte replicated to all lanes; sh wstrb = 0011<<addr[1:0], halfword replicated to both halves; sw wstrb=1111.
REQ-026 Loads: select lane(s) by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend; lw unmodified.
REQ-027 Wait counter clears on entering REQ and WAIT, increments each cycle in those states; reaching TIMEOUT without gnt/rvalid -> RESP with err=1, mem_req dropped.
REQ-028 Minimum latency accept-to-done: store 2 cycles (gnt same cycle as req), load 3 cycles (rvalid cycle after gnt).
REQ-029 mem_gnt and timeout in the same cycle: gnt wins.
REQ-030 rdata holds last value between operations; stores and errors leave rdata unchanged.
REQ-031 mem_req, mem_we, mem_wstrb low outside REQ.

Reset
REQ-032 rst=1 on a rising edge: state IDLE, lsu_ready=1, done=0, err=0, mem_req=0, mem_we=0, mem_wstrb=0000, rdata=0, counter=0.
REQ-033 Reset mid-operation aborts without done pulse; in-flight gnt/rvalid after reset ignored.

Verification
REQ-034 sw base=0x10 imm=4 wdata=0xDEADBEEF, gnt immediate -> mem_addr=0x14, wstrb=1111, mem_wdata=0xDEADBEEF, done 2 cycles after accept, err=0.
REQ-035 sb addr=0x23 wdata=0x000000A5 -> mem_addr=0x20, wstrb=1000, mem_wdata=0xA5A5A5A5.
REQ-036 lb addr=0x22, mem_rdata=0x12F0_3456 -> rdata=0xFFFFFFF0; lbu same -> 0x000000F0; lhu addr=0x22 -> 0x000012F0.
REQ-037 lw addr=0x41 -> done with err=1 one cycle after accept, mem_req never asserted.
REQ-038 Load with gnt withheld, TIMEOUT=4 -> mem_req high 4 cycles, then done with err=1, rdata unchanged.
REQ-039 rst asserted while in WAIT -> next cycle lsu_ready=1, done stays 0 despite later mem_rvalid.
